// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency ALU, with a shadow pipeline for writeback routing.
// Optional perf counters are enabled with `define ALU_ISSUE_ARB_PERF_EN.
module alu_issue_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BR_W       = 20,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned ROB_W      = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BR_W-1:0]    req_br_mask,
    input  logic [NUM_REQ*ROB_W-1:0]   req_rob_idx,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       unit_ready,
    input  logic [BR_W-1:0]            brupdate_b1_resolve_mask,
    input  logic [BR_W-1:0]            brupdate_b1_mispredict_mask,
    input  logic                       flush,
    output logic                       issue_valid,
    output logic [$clog2(NUM_REQ)-1:0] issue_src,
    output logic [BR_W-1:0]            issue_br_mask,
    output logic [ROB_W-1:0]           issue_rob_idx,
    output logic                       wb_valid,
    output logic [$clog2(NUM_REQ)-1:0] wb_src,
    output logic [ROB_W-1:0]           wb_rob_idx
`ifdef ALU_ISSUE_ARB_PERF_EN
   ,output logic [31:0]                perf_grants,
    output logic [31:0]                perf_conflicts,
    output logic [31:0]                perf_kills
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned NST   = PIPE_DEPTH - 1;

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic               handshake;
    logic [BR_W-1:0]    sel_br_mask;
    logic [ROB_W-1:0]   sel_rob_idx;
    logic               issue_kill;

    logic               st_valid [NST];
    logic [SRC_W-1:0]   st_src   [NST];
    logic [ROB_W-1:0]   st_rob   [NST];
    logic [BR_W-1:0]    st_mask  [NST];
    logic               st_kill  [NST];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i]
                        && ((req_br_mask[i*BR_W +: BR_W] & brupdate_b1_mispredict_mask) == '0)
                        && !flush;
        end
    end

    // Scan from rr_ptr with modulo wrap; first eligible index wins.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found && unit_ready && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign handshake   = |req_ready;
    assign sel_br_mask = req_br_mask[grant_idx*BR_W +: BR_W];
    assign sel_rob_idx = req_rob_idx[grant_idx*ROB_W +: ROB_W];

    assign issue_kill = issue_valid
                     && (((issue_br_mask & brupdate_b1_mispredict_mask) != '0) || flush);

    always_comb begin
        for (int unsigned k = 0; k < NST; k++) begin
            st_kill[k] = st_valid[k]
                      && (((st_mask[k] & brupdate_b1_mispredict_mask) != '0) || flush);
        end
    end

    assign wb_valid   = st_valid[NST-1] && !st_kill[NST-1] && !reset;
    assign wb_src     = st_src[NST-1];
    assign wb_rob_idx = st_rob[NST-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            issue_valid   <= 1'b0;
            issue_src     <= '0;
            issue_br_mask <= '0;
            issue_rob_idx <= '0;
            for (int unsigned k = 0; k < NST; k++) begin
                st_valid[k] <= 1'b0;
                st_src[k]   <= '0;
                st_rob[k]   <= '0;
                st_mask[k]  <= '0;
            end
        end else begin
            issue_valid <= handshake;
            if (handshake) begin
                issue_src     <= grant_idx;
                issue_br_mask <= sel_br_mask & ~brupdate_b1_resolve_mask;
                issue_rob_idx <= sel_rob_idx;
                if (32'(grant_idx) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end

            // Shadow pipeline advances unconditionally; killed entries enter as invalid.
            st_valid[0] <= issue_valid && !issue_kill;
            st_src[0]   <= issue_src;
            st_rob[0]   <= issue_rob_idx;
            st_mask[0]  <= issue_br_mask & ~brupdate_b1_resolve_mask;
            for (int unsigned k = 1; k < NST; k++) begin
                st_valid[k] <= st_valid[k-1] && !st_kill[k-1];
                st_src[k]   <= st_src[k-1];
                st_rob[k]   <= st_rob[k-1];
                st_mask[k]  <= st_mask[k-1] & ~brupdate_b1_resolve_mask;
            end
        end
    end

`ifdef ALU_ISSUE_ARB_PERF_EN
    logic [31:0] kill_cnt;
    logic [32:0] kills_sum;

    always_comb begin
        kill_cnt = {31'd0, issue_kill};
        for (int unsigned k = 0; k < NST; k++) begin
            kill_cnt = kill_cnt + {31'd0, st_kill[k]};
        end
    end

    assign kills_sum = {1'b0, perf_kills} + {1'b0, kill_cnt};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grants    <= '0;
            perf_conflicts <= '0;
            perf_kills     <= '0;
        end else begin
            if (handshake && perf_grants != '1) begin
                perf_grants <= perf_grants + 32'd1;
            end
            if (unit_ready && $countones(eligible) >= 2 && perf_conflicts != '1) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
            perf_kills <= kills_sum[32] ? '1 : kills_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios then random traffic, checked against an in-flight uop list model.
module tb_alu_issue_arbiter;
    localparam int N  = 4;
    localparam int BW = 20;
    localparam int PD = 3;
    localparam int RW = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*BW-1:0]   req_br_mask;
    logic [N*RW-1:0]   req_rob_idx;
    logic [N-1:0]      req_ready;
    logic              unit_ready;
    logic [BW-1:0]     res_mask;
    logic [BW-1:0]     mp_mask;
    logic              flush;
    logic              issue_valid;
    logic [1:0]        issue_src;
    logic [BW-1:0]     issue_br_mask;
    logic [RW-1:0]     issue_rob_idx;
    logic              wb_valid;
    logic [1:0]        wb_src;
    logic [RW-1:0]     wb_rob_idx;

    alu_issue_arbiter #(.NUM_REQ(N), .BR_W(BW), .PIPE_DEPTH(PD), .ROB_W(RW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_br_mask(req_br_mask), .req_rob_idx(req_rob_idx),
        .req_ready(req_ready), .unit_ready(unit_ready),
        .brupdate_b1_resolve_mask(res_mask), .brupdate_b1_mispredict_mask(mp_mask),
        .flush(flush),
        .issue_valid(issue_valid), .issue_src(issue_src),
        .issue_br_mask(issue_br_mask), .issue_rob_idx(issue_rob_idx),
        .wb_valid(wb_valid), .wb_src(wb_src), .wb_rob_idx(wb_rob_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          src;
        logic [RW-1:0] rob;
        logic [BW-1:0] mask;
        int          age;   // cycles since handshake
    } uop_t;

    uop_t     inflight[$];
    int       m_rr;
    int       n_assert;
    int       n_fail;
    logic [N-1:0]  s_ready;
    logic          s_wb;
    logic [RW-1:0] s_wb_rob;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs against the model mid-cycle, then advance the model.
    task automatic step();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ready;
        bit found;
        int w;
        int c;
        int ji;
        int jw;
        uop_t nxt[$];
        uop_t u;
        @(negedge clock);
        for (int i = 0; i < N; i++)
            elig[i] = req_valid[i] && ((req_br_mask[i*BW +: BW] & mp_mask) == '0) && !flush;
        found = 0;
        w = 0;
        for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!found && elig[c]) begin
                found = 1;
                w = c;
            end
        end
        exp_ready = '0;
        if (found && unit_ready) exp_ready[w] = 1'b1;
        s_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));

        ji = -1;
        jw = -1;
        foreach (inflight[j]) begin
            if (inflight[j].age == 1) ji = j;
            if (inflight[j].age == PD && ((inflight[j].mask & mp_mask) == '0) && !flush) jw = j;
        end
        chk("issue_valid", 64'(issue_valid), 64'(ji >= 0));
        if (ji >= 0) begin
            chk("issue_src", 64'(issue_src), 64'(inflight[ji].src));
            chk("issue_br_mask", 64'(issue_br_mask), 64'(inflight[ji].mask));
            chk("issue_rob_idx", 64'(issue_rob_idx), 64'(inflight[ji].rob));
        end
        s_wb = wb_valid;
        s_wb_rob = wb_rob_idx;
        chk("wb_valid", 64'(wb_valid), 64'(jw >= 0));
        if (jw >= 0) begin
            chk("wb_src", 64'(wb_src), 64'(inflight[jw].src));
            chk("wb_rob_idx", 64'(wb_rob_idx), 64'(inflight[jw].rob));
        end

        foreach (inflight[j]) begin
            u = inflight[j];
            if (((u.mask & mp_mask) == '0) && !flush && u.age < PD) begin
                u.mask &= ~res_mask;
                u.age++;
                nxt.push_back(u);
            end
        end
        if (found && unit_ready) begin
            u.src  = w;
            u.rob  = req_rob_idx[w*RW +: RW];
            u.mask = req_br_mask[w*BW +: BW] & ~res_mask;
            u.age  = 1;
            nxt.push_back(u);
            m_rr = (w + 1) % N;
        end
        inflight = nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_br_mask = '0;
        req_rob_idx = '0;
        res_mask = '0;
        mp_mask = '0;
        flush = 1'b0;
        unit_ready = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        m_rr = 0;
        idle_inputs();
        req_valid = '1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Round robin: all requesters valid for 8 cycles
        req_valid = 4'hF;
        req_rob_idx = 28'h1234567;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_grant", 64'(s_ready), 64'(4'b0001 << (i % 4)));
        end
        idle_inputs();
        repeat (PD) step();

        // Kill at arbitration
        req_valid = 4'b0110;
        req_br_mask[1*BW +: BW] = 20'h00004;
        mp_mask = 20'h00004;
        step();
        chk("kill_arb_ready", 64'(s_ready), 64'b0100);
        idle_inputs();
        repeat (PD) step();

        // Kill in flight
        req_valid = 4'b0001;
        req_rob_idx = 28'h25;
        req_br_mask = 80'h10;
        step();
        idle_inputs();
        step();
        mp_mask = 20'h10;
        step();
        mp_mask = '0;
        step();
        chk("kill_flight_wb", 64'(s_wb), 64'd0);

        // Resolve then mispredict: uop survives
        req_valid = 4'b0001;
        req_rob_idx = 28'h25;
        req_br_mask = 80'h10;
        step();
        idle_inputs();
        res_mask = 20'h10;
        step();
        res_mask = '0;
        mp_mask = 20'h10;
        step();
        mp_mask = '0;
        step();
        chk("resolve_wb_valid", 64'(s_wb), 64'd1);
        chk("resolve_wb_rob", 64'(s_wb_rob), 64'h25);

        // unit_ready stall
        req_valid = 4'b1000;
        unit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 64'(s_ready), 64'd0);
        end
        unit_ready = 1'b1;
        step();
        chk("stall_release", 64'(s_ready), 64'b1000);
        idle_inputs();
        repeat (PD) step();

        // Flush with three uops in flight
        req_valid = 4'hF;
        repeat (3) step();
        flush = 1'b1;
        step();
        chk("flush_wb", 64'(s_wb), 64'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_flush_wb", 64'(s_wb), 64'd0);
        end

        // Reset asserted mid-cycle with uops in flight
        req_valid = 4'hF;
        repeat (3) step();
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_issue_valid", 64'(issue_valid), 64'd0);
        chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        inflight.delete();
        m_rr = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                req_br_mask[i*BW +: BW] = ($urandom_range(0, 1) == 1) ? (20'h1 << $urandom_range(0, 3)) : 20'h0;
            req_rob_idx = 28'($urandom);
            unit_ready = ($urandom_range(0, 3) != 0);
            res_mask = ($urandom_range(0, 3) == 0) ? (20'h1 << $urandom_range(0, 3)) : 20'h0;
            mp_mask = ($urandom_range(0, 5) == 0) ? (20'h1 << $urandom_range(0, 3)) : 20'h0;
            flush = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
